counter_sequencer: RTL and testbench

Run-control sequencer for the lab's loadable WIDTH-bit counter datapath. It accepts a start request and latches a per-run configuration: preload, terminal value, direction, one-shot/periodic mode and prescaler. It then steps the counter at the prescaled rate and reports terminal count. It sits between the board-level control logic (switches/buttons or a host FSM) and the counter output that drives the LEDs/seven-segment display.

---
 rtl/counter_sequencer_pkg.sv | 16 +
 rtl/counter_sequencer_if.sv | 31 +++
 rtl/counter_sequencer_core.sv | 42 ++++
 rtl/counter_sequencer.sv | 118 +++++++++++
 tb/tb_counter_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter run-control sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the board-level controller and the sequencer.
interface counter_sequencer_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
);

  logic                  start;
  logic                  stop;
  logic                  mode;
  logic                  dir;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      term_val;
  logic [PRESCALE_W-1:0] prescale;

  logic                  start_ack;
  logic [WIDTH-1:0]      Q;
  logic                  busy;
  logic                  done;
  logic                  tc;

  modport master (
    output start, stop, mode, dir, load_val, term_val, prescale,
    input  start_ack, Q, busy, done, tc
  );

  modport slave (
    input  start, stop, mode, dir, load_val, term_val, prescale,
    output start_ack, Q, busy, done, tc
  );

endinterface

// File: rtl/counter_sequencer_core.sv
// Loadable WIDTH-bit up/down counter; wraps modulo 2^WIDTH.
module counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next count: load wins over a step; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = (dir == DIR_DOWN) ? (q_q - ONE) : (q_q + ONE);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer: latches a run configuration on start, paces the
// counter with a prescaler and flags terminal count.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input logic                Clk,
  input logic                Clr,
  counter_sequencer_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  state_e                state_q;
  logic [PRESCALE_W-1:0] psc_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tc_q;
  logic                  ack_q;

  logic                  shd_mode_q;
  logic                  shd_dir_q;
  logic [WIDTH-1:0]      shd_load_q;
  logic [WIDTH-1:0]      shd_term_q;
  logic [PRESCALE_W-1:0] shd_psc_q;

  logic                  abort_d;
  logic                  accept_d;
  logic                  tick_d;
  logic                  at_term_d;
  logic                  core_load_d;
  logic                  core_en_d;
  logic [WIDTH-1:0]      core_load_val_d;
  logic [WIDTH-1:0]      q;

  // Decode this cycle's events; stop outranks both start and a due tick.
  always_comb begin
    abort_d         = bus.stop && (state_q != IDLE);
    accept_d        = bus.start && !bus.stop && (state_q != RUN);
    tick_d          = (state_q == RUN) && !bus.stop && (psc_q == shd_psc_q);
    at_term_d       = (q == shd_term_q);
    core_load_d     = accept_d || (tick_d && at_term_d && (shd_mode_q == MODE_PERIODIC));
    core_load_val_d = accept_d ? bus.load_val : shd_load_q;
    core_en_d       = tick_d && !at_term_d;
  end

  // Shadow configuration, refreshed only when a start is accepted.
  always_ff @(posedge Clk) begin
    if (accept_d) begin
      shd_mode_q <= bus.mode;
      shd_dir_q  <= bus.dir;
      shd_load_q <= bus.load_val;
      shd_term_q <= bus.term_val;
      shd_psc_q  <= bus.prescale;
    end
  end

  // Sequencer FSM with prescaler and registered status outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      psc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      tc_q  <= 1'b0;
      if (abort_d) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (accept_d) begin
        state_q <= RUN;
        psc_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        ack_q   <= 1'b1;
      end else if (state_q == RUN) begin
        if (tick_d) begin
          psc_q <= '0;
          if (at_term_d) begin
            tc_q <= 1'b1;
            if (shd_mode_q == MODE_ONESHOT) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end else begin
          psc_q <= psc_q + PSC_ONE;
        end
      end
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .Clk      (Clk),
    .Clr      (Clr),
    .load     (core_load_d),
    .load_val (core_load_val_d),
    .en       (core_en_d),
    .dir      (shd_dir_q),
    .Q        (q)
  );

  assign bus.Q         = q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tc        = tc_q;
  assign bus.start_ack = ack_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer: vector table, directed corner sequences
// and randomized traffic against a behavioural model.
module tb_counter_sequencer;

  localparam int WIDTH = 4;
  localparam int PW    = 8;
  localparam int MOD   = 1 << WIDTH;
  localparam int NV    = 18;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    int start, stop, mode, dir, ld, tm, ps;
    int q, busy, done, tc, ack;
  } vec_t;

  logic Clk = 1'b0;
  logic Clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  int m_st, m_q, m_busy, m_done, m_tc, m_ack, m_k;
  int c_mode, c_dir, c_ld, c_tm, c_ps;

  vec_t tbl [NV];

  always #5 Clk = ~Clk;

  counter_sequencer_if #(.WIDTH(WIDTH), .PRESCALE_W(PW)) bus ();

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input int st, input int sp, input int md, input int dr,
                        input int ld, input int tm, input int ps);
    bus.start    = 1'(st);
    bus.stop     = 1'(sp);
    bus.mode     = 1'(md);
    bus.dir      = 1'(dr);
    bus.load_val = WIDTH'(ld);
    bus.term_val = WIDTH'(tm);
    bus.prescale = PW'(ps);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_q = 0; m_busy = 0; m_done = 0; m_tc = 0; m_ack = 0; m_k = 0;
  endtask

  // Behavioural model: ticks fall on every (prescale+1)-th edge after the start.
  task automatic model_step();
    m_ack = 0;
    m_tc  = 0;
    if (bus.stop && m_st != M_IDLE) begin
      m_st = M_IDLE; m_busy = 0; m_done = 0;
    end else if (bus.start && !bus.stop && m_st != M_RUN) begin
      c_mode = int'(bus.mode);
      c_dir  = int'(bus.dir);
      c_ld   = int'(bus.load_val);
      c_tm   = int'(bus.term_val);
      c_ps   = int'(bus.prescale);
      m_q = c_ld; m_k = 0; m_st = M_RUN; m_busy = 1; m_done = 0; m_ack = 1;
    end else if (m_st == M_RUN) begin
      m_k++;
      if (m_k % (c_ps + 1) == 0) begin
        if (m_q == c_tm) begin
          m_tc = 1;
          if (c_mode == 0) begin
            m_st = M_DONE; m_busy = 0; m_done = 1;
          end else begin
            m_q = c_ld;
          end
        end else begin
          m_q = (m_q + (c_dir != 0 ? -1 : 1) + MOD) % MOD;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".Q"},    int'(bus.Q),         m_q);
    chk({tag, ".busy"}, int'(bus.busy),      m_busy);
    chk({tag, ".done"}, int'(bus.done),      m_done);
    chk({tag, ".tc"},   int'(bus.tc),        m_tc);
    chk({tag, ".ack"},  int'(bus.start_ack), m_ack);
  endtask

  initial begin
    //             st sp md dr ld tm ps    q  b  d tc ack
    tbl[0]  = '{1, 0, 0, 0, 2, 5, 0,   2, 1, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,   5, 0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0,   5, 0, 1, 0, 0};
    tbl[6]  = '{1, 0, 1, 1, 1, 14, 0,  1, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,  15, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,  14, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0,  15, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0,  14, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0};
    tbl[15] = '{1, 0, 0, 0, 7, 7, 0,   0, 1, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge Clk);
    chk("rst.Q",    int'(bus.Q),         0);
    chk("rst.busy", int'(bus.busy),      0);
    chk("rst.done", int'(bus.done),      0);
    chk("rst.tc",   int'(bus.tc),        0);
    chk("rst.ack",  int'(bus.start_ack), 0);
    Clr = 1'b1;
    @(negedge Clk);

    // Table: one-shot up, restart from DONE into periodic down with wrap,
    // start ignored in RUN, stop from RUN, stop in IDLE.
    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].dir,
             tbl[i].ld, tbl[i].tm, tbl[i].ps);
      step();
      chk($sformatf("tbl%0d.Q", i),    int'(bus.Q),         tbl[i].q);
      chk($sformatf("tbl%0d.busy", i), int'(bus.busy),      tbl[i].busy);
      chk($sformatf("tbl%0d.done", i), int'(bus.done),      tbl[i].done);
      chk($sformatf("tbl%0d.tc", i),   int'(bus.tc),        tbl[i].tc);
      chk($sformatf("tbl%0d.ack", i),  int'(bus.start_ack), tbl[i].ack);
    end

    // Prescaler = 3: steps at N+4, N+8, tc at N+12, one clock wide.
    set_in(1, 0, 0, 0, 0, 2, 3);
    step();
    chk("psc.ack", int'(bus.start_ack), 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 13; i++) begin
      step();
      chk($sformatf("psc%0d.Q", i),  int'(bus.Q),  (i < 4) ? 0 : (i < 8) ? 1 : 2);
      chk($sformatf("psc%0d.tc", i), int'(bus.tc), (i == 12) ? 1 : 0);
    end
    chk("psc.done", int'(bus.done), 1);
    set_in(0, 1, 0, 0, 0, 0, 0);
    step();
    chk("psc.stop_done", int'(bus.done), 0);

    // Stop + start together on the cycle a terminal tick is due.
    set_in(1, 0, 0, 0, 3, 3, 2);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_in(1, 1, 0, 0, 9, 9, 0);
    step();
    chk("stp.busy", int'(bus.busy),      0);
    chk("stp.done", int'(bus.done),      0);
    chk("stp.tc",   int'(bus.tc),        0);
    chk("stp.ack",  int'(bus.start_ack), 0);
    chk("stp.Q",    int'(bus.Q),         3);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("stp.tc2",  int'(bus.tc), 0);
    chk("stp.Q2",   int'(bus.Q),  3);

    // Config changes during a run are ignored until the next start.
    set_in(1, 0, 0, 0, 4, 6, 1);
    step();
    chk("cfg.ack", int'(bus.start_ack), 1);
    chk("cfg.Q0",  int'(bus.Q), 4);
    set_in(0, 0, 1, 1, 10, 12, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("cfg%0d.Q", i),  int'(bus.Q),  (i < 2) ? 4 : (i < 4) ? 5 : 6);
      chk($sformatf("cfg%0d.tc", i), int'(bus.tc), (i == 6) ? 1 : 0);
    end
    chk("cfg.done", int'(bus.done), 1);
    set_in(1, 0, 0, 0, 10, 12, 0);
    step();
    chk("cfg.ack2",  int'(bus.start_ack), 1);
    chk("cfg.Q10",   int'(bus.Q),         10);
    chk("cfg.busy2", int'(bus.busy),      1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("cfg.Q11",  int'(bus.Q),         11);
    chk("cfg.ack3", int'(bus.start_ack), 0);
    step();
    step();
    chk("cfg.tc2",  int'(bus.tc),   1);
    chk("cfg.Q12",  int'(bus.Q),    12);

    // Asynchronous reset mid-run.
    set_in(1, 0, 0, 0, 1, 9, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("arst.pre_Q",    int'(bus.Q),    3);
    chk("arst.pre_busy", int'(bus.busy), 1);
    Clr = 1'b0;
    #1;
    chk("arst.Q",    int'(bus.Q),    0);
    chk("arst.busy", int'(bus.busy), 0);
    chk("arst.tc",   int'(bus.tc),   0);
    model_reset();
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    step();
    step();
    chk_model("arst.post");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 7) == 0) ? 1 : 0,
             ($urandom_range(0, 19) == 0) ? 1 : 0,
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
             int'($urandom_range(0, 3)));
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
